// File: rtl/stereo_frame_sequencer_if.sv
// Bundle of the pixel-stream, core-facing and status signals of the stereo
// frame sequencer. The sequencer sits on the slave side; the producer side
// (pixel FIFOs, control, core feedback) uses the master modport.
interface stereo_frame_sequencer_if #(
  parameter int N    = 8,
  parameter int DBIT = 6
);
  // Frame control
  logic            i_start;
  logic [DBIT-1:0] i_thresh;

  // Left / right pixel streams
  logic            i_l_valid;
  logic [N-1:0]    i_l_data;
  logic            o_l_ready;
  logic            i_r_valid;
  logic [N-1:0]    i_r_data;
  logic            o_r_ready;

  // Towards the stereo_match core
  logic [N-1:0]    o_core_data_l;
  logic [N-1:0]    o_core_data_r;
  logic            o_core_dval;
  logic [DBIT-1:0] o_core_thresh;

  // Back from the stereo_match core
  logic            i_core_dval;

  // Status
  logic            o_busy;
  logic            o_frame_done;
  logic [31:0]     o_out_cnt;

  modport master (
    output i_start, i_thresh,
    output i_l_valid, i_l_data, i_r_valid, i_r_data,
    output i_core_dval,
    input  o_l_ready, o_r_ready,
    input  o_core_data_l, o_core_data_r, o_core_dval, o_core_thresh,
    input  o_busy, o_frame_done, o_out_cnt
  );

  modport slave (
    input  i_start, i_thresh,
    input  i_l_valid, i_l_data, i_r_valid, i_r_data,
    input  i_core_dval,
    output o_l_ready, o_r_ready,
    output o_core_data_l, o_core_data_r, o_core_dval, o_core_thresh,
    output o_busy, o_frame_done, o_out_cnt
  );
endinterface

// File: rtl/stereo_frame_sequencer.sv
// Frame sequencer in front of the stereo_match core.
// Pairs left/right pixels, issues them to the core one line at a time with
// horizontal blanking between lines, appends flush pixels after the last line
// to drain the core pipeline, and counts the core's output pixels.
// All core-facing and status outputs are registered, so they show what the
// FSM decided one cycle earlier; the stream readies are the only
// combinational outputs.
module stereo_frame_sequencer #(
  parameter int N    = 8,
  parameter int D    = 64,
  parameter int M    = 450,
  parameter int ROWS = 375,
  parameter int HB   = 16,
  parameter int FL   = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  stereo_frame_sequencer_if.slave bus
);

  localparam int DBIT = $clog2(D);
  localparam int CW   = (M    > 1) ? $clog2(M)    : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW   = (HB   > 1) ? $clog2(HB)   : 1;
  localparam int FW   = (FL   > 1) ? $clog2(FL)   : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(M - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(HB - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LINE,
    S_HBLANK,
    S_FLUSH,
    S_DONE
  } state_e;

  // FSM state and position counters
  state_e          state_q, state_d;
  logic [CW-1:0]   col_q,   col_d;
  logic [RW-1:0]   row_q,   row_d;
  logic [BW-1:0]   blank_q, blank_d;
  logic [FW-1:0]   flush_q, flush_d;

  // Registered outputs
  logic [N-1:0]    data_l_q, data_l_d;
  logic [N-1:0]    data_r_q, data_r_d;
  logic            dval_q,   dval_d;
  logic [DBIT-1:0] thresh_q, thresh_d;
  logic [31:0]     cnt_q,    cnt_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;

  logic handshake;
  logic start_accept;

  // A pixel pair is consumed only when both sides are valid during a line.
  assign handshake = (state_q == S_LINE) && bus.i_l_valid && bus.i_r_valid;

  // busy_q stays high for the frame_done cycle, so a start there is ignored.
  assign start_accept = (state_q == S_IDLE) && bus.i_start && !busy_q;

  // State register and position counters.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      blank_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      blank_q <= blank_d;
      flush_q <= flush_d;
    end
  end

  // Next-state and counter update logic.
  // NOTE: every variable gets a hold default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    blank_d = blank_q;
    flush_d = flush_q;
    case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          state_d = S_LINE;
          col_d   = '0;
          row_d   = '0;
          blank_d = '0;
          flush_d = '0;
        end
      end
      S_LINE: begin
        if (handshake) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_FLUSH;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = S_HBLANK;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_HBLANK: begin
        if (blank_q == BLANK_LAST) begin
          blank_d = '0;
          state_d = S_LINE;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          flush_d = '0;
          state_d = S_DONE;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: core pixel issue, threshold latch, status and core counter.
  always_comb begin
    dval_d   = 1'b0;
    data_l_d = data_l_q;
    data_r_d = data_r_q;
    case (state_q)
      S_LINE: begin
        if (handshake) begin
          dval_d   = 1'b1;
          data_l_d = bus.i_l_data;
          data_r_d = bus.i_r_data;
        end
      end
      S_FLUSH: begin
        dval_d   = 1'b1;
        data_l_d = '0;
        data_r_d = '0;
      end
      default: ;
    endcase

    busy_d   = (state_q != S_IDLE);
    done_d   = (state_q == S_DONE);
    thresh_d = start_accept ? bus.i_thresh : thresh_q;

    // A start clears the counter; a core pulse in that same cycle belongs to
    // the previous frame and is dropped.
    if (start_accept) begin
      cnt_d = '0;
    end else if (bus.i_core_dval && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      data_l_q <= '0;
      data_r_q <= '0;
      dval_q   <= 1'b0;
      thresh_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      data_l_q <= data_l_d;
      data_r_q <= data_r_d;
      dval_q   <= dval_d;
      thresh_q <= thresh_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_l_ready     = handshake;
  assign bus.o_r_ready     = handshake;
  assign bus.o_core_data_l = data_l_q;
  assign bus.o_core_data_r = data_r_q;
  assign bus.o_core_dval   = dval_q;
  assign bus.o_core_thresh = thresh_q;
  assign bus.o_out_cnt     = cnt_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_frame_done  = done_q;

endmodule

// File: tb/tb_stereo_frame_sequencer.sv
// Self-checking bench for stereo_frame_sequencer: a 4x2 frame instance for the
// main scenarios and a 4x1 instance for the single-row boundary case.
module tb_stereo_frame_sequencer;

  localparam int N    = 8;
  localparam int D    = 64;
  localparam int DBIT = 6;
  localparam int M    = 4;
  localparam int ROWS = 2;
  localparam int HB   = 3;
  localparam int FL   = 5;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  stereo_frame_sequencer_if #(.N(N), .DBIT(DBIT)) if0 ();
  stereo_frame_sequencer_if #(.N(N), .DBIT(DBIT)) if1 ();

  stereo_frame_sequencer #(.N(N), .D(D), .M(M), .ROWS(ROWS), .HB(HB), .FL(FL)) dut0 (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (if0)
  );

  stereo_frame_sequencer #(.N(N), .D(D), .M(M), .ROWS(1), .HB(HB), .FL(FL)) dut1 (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (if1)
  );

  typedef struct {
    logic [N-1:0] l;
    logic [N-1:0] r;
  } pix_t;

  typedef struct {
    int          dval_n;
    int          done_n;
    int          first_c;
    int          done_c;
    logic [31:0] cnt_c1;
    logic [31:0] cnt_done;
    logic [31:0] cnt_idle;
    logic        busy_done;
    logic        busy_after;
    logic        dval_at_done;
    int          bad_thr;
    int          bad_rdy;
    logic [63:0] log;
  } res_t;

  pix_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic idle_inputs();
    if0.i_start = 1'b0; if0.i_thresh = '0; if0.i_core_dval = 1'b0;
    if0.i_l_valid = 1'b0; if0.i_l_data = '0; if0.i_r_valid = 1'b0; if0.i_r_data = '0;
    if1.i_start = 1'b0; if1.i_thresh = '0; if1.i_core_dval = 1'b0;
    if1.i_l_valid = 1'b0; if1.i_l_data = '0; if1.i_r_valid = 1'b0; if1.i_r_data = '0;
  endtask

  // Expected core issue order for one frame: M*rows real pairs then FL zeros.
  task automatic load_frame(input int rows);
    pix_t p;
    sb.delete();
    for (int i = 0; i < M * rows; i++) begin
      p.l = N'(i + 1);
      p.r = N'(8'h40 + i + 1);
      sb.push_back(p);
    end
    for (int i = 0; i < FL; i++) begin
      p.l = '0;
      p.r = '0;
      sb.push_back(p);
    end
  endtask

  // Runs one frame on dut0. Stimulus is set 1 time unit after each rising edge,
  // outputs are sampled on the falling edge. Iteration 0 presents the start.
  task automatic run_frame(input int thr, input bit r_alt, input int n_pulse,
                           input int restart_c, input int abort_c, output res_t res);
    int   k = 0;
    int   nc;
    bit   aborted = 1'b0;
    pix_t e;
    res = '{default: 0};
    res.first_c = -1;
    res.done_c  = -1;
    load_frame(ROWS);
    @(posedge clk); #1;
    if0.i_start   = 1'b1;
    if0.i_thresh  = DBIT'(thr);
    if0.i_l_valid = 1'b1;
    if0.i_r_valid = 1'b1;
    if0.i_l_data  = N'(1);
    if0.i_r_data  = N'(8'h41);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c >= 1 && if0.o_core_thresh !== DBIT'(thr)) res.bad_thr++;
      if ((if0.o_l_ready !== if0.o_r_ready) ||
          (if0.o_l_ready && !(if0.i_l_valid && if0.i_r_valid))) res.bad_rdy++;
      if (c == 1) res.cnt_c1 = if0.o_out_cnt;
      if (c < 64) res.log[c] = if0.o_core_dval;
      if (if0.o_core_dval) begin
        res.dval_n++;
        if (res.first_c < 0) res.first_c = c;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL core_pixel_extra: got l=%0h r=%0h at cycle %0d, required no pixel",
                   if0.o_core_data_l, if0.o_core_data_r, c);
        end else begin
          e = sb.pop_front();
          if (if0.o_core_data_l !== e.l || if0.o_core_data_r !== e.r)
            $display("FAIL core_pixel: got l=%0h r=%0h, required l=%0h r=%0h",
                     if0.o_core_data_l, if0.o_core_data_r, e.l, e.r);
          else n_pass++;
        end
      end
      if (res.done_c >= 0 && c == res.done_c + 1) begin
        res.busy_after = if0.o_busy;
        res.cnt_idle   = if0.o_out_cnt;
        break;
      end
      if (if0.o_frame_done) begin
        res.done_n++;
        if (res.done_c < 0) begin
          res.done_c       = c;
          res.cnt_done     = if0.o_out_cnt;
          res.busy_done    = if0.o_busy;
          res.dval_at_done = if0.o_core_dval;
        end
      end
      if (if0.o_l_ready) k++;
      if (c == abort_c) begin
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({if0.o_busy, if0.o_frame_done, if0.o_core_dval, if0.o_core_data_l,
             if0.o_core_data_r, if0.o_core_thresh, if0.o_out_cnt} !== '0)
          $display("FAIL abort_outputs_zero: got busy=%0b done=%0b dval=%0b l=%0h r=%0h thr=%0d cnt=%0d, required all 0",
                   if0.o_busy, if0.o_frame_done, if0.o_core_dval, if0.o_core_data_l,
                   if0.o_core_data_r, if0.o_core_thresh, if0.o_out_cnt);
        else n_pass++;
        n_checks++;
        if ({if0.o_l_ready, if0.o_r_ready} !== 2'b00 || !if0.i_l_valid)
          $display("FAIL abort_ready_idle: got readies=%0b%0b with valids high, required 00",
                   if0.o_l_ready, if0.o_r_ready);
        else n_pass++;
        aborted = 1'b1;
        break;
      end
      @(posedge clk); #1;
      nc = c + 1;
      if0.i_start = (nc == restart_c);
      if (restart_c > 0 && nc >= restart_c) if0.i_thresh = DBIT'(20);
      if0.i_l_valid   = (k < M * ROWS);
      if0.i_r_valid   = (k < M * ROWS) && (!r_alt || (nc % 2 == 0));
      if0.i_l_data    = N'(k + 1);
      if0.i_r_data    = N'(8'h40 + k + 1);
      if0.i_core_dval = (nc >= 2) && (nc < 2 + n_pulse);
    end
    idle_inputs();
    if (aborted) begin
      @(posedge clk); #1;
      rstn = 1'b1;
      sb.delete();
    end
  endtask

  task automatic check_frame_common(input string tag, input res_t res);
    n_checks++;
    if (res.dval_n !== M * ROWS + FL)
      $display("FAIL %s_dval_count: got %0d, required %0d", tag, res.dval_n, M * ROWS + FL);
    else n_pass++;
    n_checks++;
    if (res.done_n !== 1) $display("FAIL %s_done_pulses: got %0d, required 1", tag, res.done_n);
    else n_pass++;
    n_checks++;
    if (sb.size() != 0) $display("FAIL %s_scoreboard_left: got %0d pending, required 0", tag, sb.size());
    else n_pass++;
    n_checks++;
    if (res.bad_rdy !== 0) $display("FAIL %s_ready_rule: got %0d bad cycles, required 0", tag, res.bad_rdy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    if0.i_l_valid = 1'b1;
    if0.i_r_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({if0.o_busy, if0.o_frame_done, if0.o_core_dval, if0.o_l_ready, if0.o_r_ready,
         if0.o_core_data_l, if0.o_core_data_r, if0.o_core_thresh, if0.o_out_cnt} !== '0)
      $display("FAIL reset_outputs: got busy=%0b done=%0b dval=%0b rdy=%0b%0b thr=%0d cnt=%0d, required all 0",
               if0.o_busy, if0.o_frame_done, if0.o_core_dval, if0.o_l_ready, if0.o_r_ready,
               if0.o_core_thresh, if0.o_out_cnt);
    else n_pass++;
    @(posedge clk); #1;
    rstn = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic_frame();
    res_t res;
    logic [63:0] win;
    run_frame(8, 1'b0, 0, -1, -1, res);
    check_frame_common("basic", res);
    win = res.log >> res.first_c;
    n_checks++;
    if (win[16:0] !== 17'h0FF8F)
      $display("FAIL basic_dval_pattern: got %05h, required 0ff8f (4 on, 3 off, 9 on)", win[16:0]);
    else n_pass++;
    n_checks++;
    if (res.done_c - res.first_c !== 16)
      $display("FAIL basic_done_timing: got %0d cycles after first pixel, required 16", res.done_c - res.first_c);
    else n_pass++;
    n_checks++;
    if (res.bad_thr !== 0) $display("FAIL basic_thresh: got %0d bad cycles, required 0", res.bad_thr);
    else n_pass++;
    n_checks++;
    if ({res.busy_done, res.busy_after, res.dval_at_done} !== 3'b100)
      $display("FAIL basic_busy_done: got busy@done=%0b busy@idle=%0b dval@done=%0b, required 1 0 0",
               res.busy_done, res.busy_after, res.dval_at_done);
    else n_pass++;
  endtask

  task automatic test_stall();
    res_t res;
    logic [63:0] win;
    run_frame(8, 1'b1, 0, -1, -1, res);
    check_frame_common("stall", res);
    win = res.log >> res.first_c;
    n_checks++;
    if (win[2:0] !== 3'b101)
      $display("FAIL stall_dval_gaps: got %03b, required 101", win[2:0]);
    else n_pass++;
  endtask

  task automatic test_restart_ignored();
    res_t res;
    run_frame(8, 1'b0, 0, 6, -1, res);
    check_frame_common("restart", res);
    n_checks++;
    if (res.bad_thr !== 0) $display("FAIL restart_thresh: got %0d cycles not 8, required 0", res.bad_thr);
    else n_pass++;
  endtask

  task automatic test_out_cnt();
    res_t res;
    run_frame(8, 1'b0, 7, -1, -1, res);
    check_frame_common("outcnt", res);
    n_checks++;
    if (res.cnt_done !== 32'd7) $display("FAIL outcnt_at_done: got %0d, required 7", res.cnt_done);
    else n_pass++;
    n_checks++;
    if (res.cnt_idle !== 32'd7) $display("FAIL outcnt_in_idle: got %0d, required 7", res.cnt_idle);
    else n_pass++;
    run_frame(8, 1'b0, 0, -1, -1, res);
    n_checks++;
    if (res.cnt_c1 !== 32'd0) $display("FAIL outcnt_cleared: got %0d, required 0", res.cnt_c1);
    else n_pass++;
  endtask

  task automatic test_abort();
    res_t res;
    run_frame(8, 1'b0, 3, -1, 6, res);
    n_checks++;
    if (res.done_n !== 0) $display("FAIL abort_no_done: got %0d pulses, required 0", res.done_n);
    else n_pass++;
    repeat (2) @(posedge clk);
    run_frame(8, 1'b0, 0, -1, -1, res);
    check_frame_common("after_abort", res);
  endtask

  task automatic test_rows1();
    int   k = 0;
    int   dval_n = 0;
    int   first_c = -1;
    int   done_c = -1;
    int   done_n = 0;
    logic [63:0] log = '0;
    logic [63:0] win;
    pix_t e;
    load_frame(1);
    @(posedge clk); #1;
    if1.i_start = 1'b1; if1.i_thresh = DBIT'(8);
    if1.i_l_valid = 1'b1; if1.i_r_valid = 1'b1;
    if1.i_l_data = N'(1); if1.i_r_data = N'(8'h41);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c < 64) log[c] = if1.o_core_dval;
      if (if1.o_core_dval) begin
        dval_n++;
        if (first_c < 0) first_c = c;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL rows1_pixel_extra: got l=%0h r=%0h, required no pixel",
                   if1.o_core_data_l, if1.o_core_data_r);
        end else begin
          e = sb.pop_front();
          if (if1.o_core_data_l !== e.l || if1.o_core_data_r !== e.r)
            $display("FAIL rows1_pixel: got l=%0h r=%0h, required l=%0h r=%0h",
                     if1.o_core_data_l, if1.o_core_data_r, e.l, e.r);
          else n_pass++;
        end
      end
      if (if1.o_frame_done) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c > done_c) break;
      if (if1.o_l_ready) k++;
      @(posedge clk); #1;
      if1.i_start   = 1'b0;
      if1.i_l_valid = (k < M);
      if1.i_r_valid = (k < M);
      if1.i_l_data  = N'(k + 1);
      if1.i_r_data  = N'(8'h40 + k + 1);
    end
    idle_inputs();
    win = log >> first_c;
    n_checks++;
    if (dval_n !== M + FL) $display("FAIL rows1_dval_count: got %0d, required %0d", dval_n, M + FL);
    else n_pass++;
    n_checks++;
    if (win[9:0] !== 10'h1FF) $display("FAIL rows1_no_blank: got %03h, required 1ff", win[9:0]);
    else n_pass++;
    n_checks++;
    if (done_n !== 1 || done_c - first_c !== 9)
      $display("FAIL rows1_done: got %0d pulses at +%0d, required 1 at +9", done_n, done_c - first_c);
    else n_pass++;
    n_checks++;
    if (sb.size() != 0) $display("FAIL rows1_scoreboard_left: got %0d pending, required 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_restart_ignored();
    test_out_cnt();
    test_abort();
    test_rows1();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
